// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared FSM type, default geometry/latency constants and counter helper
package sram_pkg;

    localparam int DEF_ADDR_W    = 18;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_READ_LAT  = 2;
    localparam int DEF_WRITE_LAT = 2;
    localparam int CNT_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_WAIT  = 3'd1,
        ST_RD_DRIVE = 3'd2,
        ST_WR_WAIT  = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_t;

    // Saturating increment: the latency counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : CNT_W'(32'(v) + 1);
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - asynchronous-SRAM style pin bundle between controller and responder
interface sram_responder_if import sram_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              CS;
    logic              OE;
    logic              WE;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_pins_in;
    logic [DATA_W-1:0] data_pins_out;
    logic              data_out_en;
    logic              busy;
    logic              err;

    modport master (
        output CS, OE, WE, address, data_pins_in,
        input  data_pins_out, data_out_en, busy, err
    );

    modport slave (
        input  CS, OE, WE, address, data_pins_in,
        output data_pins_out, data_out_en, busy, err
    );

endinterface

// File: rtl/sram_mem_array.sv
// rtl/sram_mem_array.sv - single-port storage, synchronous write and synchronous read, never reset
module sram_mem_array import sram_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - SRAM pin-protocol responder: latency-timed reads, hold-qualified writes
module sram_responder import sram_pkg::*; #(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int READ_LAT  = DEF_READ_LAT,
    parameter int WRITE_LAT = DEF_WRITE_LAT
) (
    input  logic               clk,
    input  logic               reset,
    sram_responder_if.slave    bus
);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT - 1);
    // The accepting edge already counts as the first write-hold cycle.
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'((WRITE_LAT > 1) ? WRITE_LAT - 2 : 0);
    localparam bit               WR_NOW  = (WRITE_LAT == 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              den_q, den_d;
    logic              err_q, err_d;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic cs_a, oe_a, we_a, wr_req, rd_req, rd_hold, wr_hold, addr_same, wr_abort;

    assign cs_a      = ~bus.CS;
    assign oe_a      = ~bus.OE;
    assign we_a      = ~bus.WE;
    assign wr_req    = cs_a & we_a & ~oe_a;
    assign rd_req    = cs_a & oe_a & ~we_a;
    assign rd_hold   = cs_a & oe_a;
    assign wr_hold   = cs_a & we_a;
    assign addr_same = (bus.address == addr_q);
    assign wr_abort  = ~wr_hold | oe_a | ~addr_same;

    // Live address while a new access (or a re-address in RD_DRIVE) can start, latched otherwise.
    assign mem_addr = (state_q == ST_IDLE || state_q == ST_RD_DRIVE) ? bus.address : addr_q;

    sram_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we & reset),
        .addr  (mem_addr),
        .wdata (bus.data_pins_in),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_req)      state_d = WR_NOW ? ST_WR_HOLD : ST_WR_WAIT;
                else if (rd_req) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (!rd_hold)             state_d = ST_IDLE;
                else if (cnt_q == RD_LAST) state_d = ST_RD_DRIVE;
            end
            ST_RD_DRIVE: begin
                if (!rd_hold)       state_d = ST_IDLE;
                else if (!addr_same) state_d = ST_RD_WAIT;
            end
            ST_WR_WAIT: begin
                if (wr_abort)             state_d = ST_IDLE;
                else if (cnt_q == WR_LAST) state_d = ST_WR_HOLD;
            end
            ST_WR_HOLD: begin
                if (!wr_hold) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        cnt_d  = sat_inc(cnt_q);
        dout_d = '0;
        den_d  = 1'b0;
        err_d  = 1'b0;
        mem_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                err_d = cs_a & oe_a & we_a;
                if (wr_req || rd_req) begin
                    addr_d = bus.address;
                end
                mem_we = wr_req & WR_NOW;
            end
            ST_RD_WAIT: begin
                if (rd_hold && cnt_q == RD_LAST) begin
                    dout_d = mem_rdata;
                    den_d  = 1'b1;
                end
            end
            ST_RD_DRIVE: begin
                if (rd_hold && !addr_same) begin
                    addr_d = bus.address;
                    cnt_d  = '0;
                end else if (rd_hold) begin
                    dout_d = dout_q;
                    den_d  = 1'b1;
                end
            end
            ST_WR_WAIT: begin
                err_d  = wr_abort;
                mem_we = ~wr_abort & (cnt_q == WR_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            den_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            den_q  <= den_d;
            err_q  <= err_d;
        end
    end

    assign bus.data_pins_out = dout_q;
    assign bus.data_out_en   = den_q;
    assign bus.err           = err_q;
    assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed and randomized checks of sram_responder against a memory model
module tb_sram_responder;

    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 16;
    localparam int READ_LAT  = 2;
    localparam int WRITE_LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_responder #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .READ_LAT  (READ_LAT),
        .WRITE_LAT (WRITE_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.CS = 1'b1;
        bus.OE = 1'b1;
        bus.WE = 1'b1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".den"},  32'(bus.data_out_en), 32'd0);
        chk({tag, ".dout"}, 32'(bus.data_pins_out), 32'd0);
        chk({tag, ".err"},  32'(bus.err), 32'd0);
    endtask

    // A write commits only when CS/WE stay low for WRITE_LAT sampled cycles; shorter holds are errors.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [DATA_W-1:0] d_late, input int hold, input string tag);
        bus.OE = 1'b1;
        bus.WE = 1'b0;
        bus.CS = 1'b0;
        bus.address = a;
        bus.data_pins_in = d;
        for (int i = 0; i < hold; i++) begin
            cyc();
            if (i == 0) chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
            if (i + 1 == WRITE_LAT) bus.data_pins_in = d_late;
        end
        bus_idle();
        cyc();
        chk({tag, ".err"}, 32'(bus.err), 32'(hold < WRITE_LAT));
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
        cyc();
        chk({tag, ".err_end"}, 32'(bus.err), 32'd0);
        if (hold >= WRITE_LAT) ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string tag);
        bus.WE = 1'b1;
        bus.OE = 1'b0;
        bus.CS = 1'b0;
        bus.address = a;
        cyc();
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        chk({tag, ".den0"}, 32'(bus.data_out_en), 32'd0);
        for (int k = 1; k < READ_LAT; k++) begin
            cyc();
            chk({tag, ".den_wait"}, 32'(bus.data_out_en), 32'd0);
        end
        cyc();
        chk({tag, ".den"},  32'(bus.data_out_en), 32'd1);
        chk({tag, ".data"}, 32'(bus.data_pins_out), 32'(exp));
        cyc();
        chk({tag, ".hold"}, 32'(bus.data_pins_out), 32'(exp));
        bus_idle();
        cyc();
        chk({tag, ".den_off"},  32'(bus.data_out_en), 32'd0);
        chk({tag, ".dout_off"}, 32'(bus.data_pins_out), 32'd0);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd, rl;
        int                rh;

        bus_idle();
        bus.address = '0;
        bus.data_pins_in = '0;
        cyc();
        cyc();
        chk_quiet("reset");
        reset = 1'b1;
        cyc();

        do_write(18'h00000, 16'hAAAA, 16'hAAAA, 2, "w_aaaa");
        do_read(18'h00000, 16'hAAAA, "r_aaaa");

        do_write(18'h00010, 16'h0F0F, 16'h0F0F, 2, "w_pre10");
        do_write(18'h00010, 16'hBEEF, 16'hBEEF, 1, "w_short");
        do_read(18'h00010, ref_mem[18'h00010], "r_short");

        do_write(18'h00030, 16'h1111, 16'h1111, 2, "w_pre30");
        bus.CS = 1'b0;
        bus.OE = 1'b0;
        bus.WE = 1'b0;
        bus.address = 18'h00030;
        bus.data_pins_in = 16'hDEAD;
        cyc();
        chk("illegal.err", 32'(bus.err), 32'd1);
        chk("illegal.busy", 32'(bus.busy), 32'd0);
        bus_idle();
        cyc();
        chk("illegal.err_end", 32'(bus.err), 32'd0);
        do_read(18'h00030, ref_mem[18'h00030], "r_illegal");

        do_write(18'h00001, 16'h0A0A, 16'h0A0A, 2, "w_0a0a");
        bus.WE = 1'b1;
        bus.OE = 1'b0;
        bus.CS = 1'b0;
        bus.address = 18'h00000;
        for (int k = 0; k <= READ_LAT; k++) cyc();
        chk("readdr.first", 32'(bus.data_pins_out), 32'(ref_mem[18'h00000]));
        bus.address = 18'h00001;
        cyc();
        chk("readdr.drop", 32'(bus.data_out_en), 32'd0);
        for (int k = 1; k < READ_LAT; k++) begin
            cyc();
            chk("readdr.wait", 32'(bus.data_out_en), 32'd0);
        end
        cyc();
        chk("readdr.den", 32'(bus.data_out_en), 32'd1);
        chk("readdr.data", 32'(bus.data_pins_out), 32'h0A0A);

        #2 reset = 1'b0;
        #1 chk_quiet("rst_read");
        bus_idle();
        cyc();
        reset = 1'b1;
        cyc();

        do_write(18'h00020, 16'h7777, 16'h7777, 2, "w_pre20");
        bus.OE = 1'b1;
        bus.WE = 1'b0;
        bus.CS = 1'b0;
        bus.address = 18'h00020;
        bus.data_pins_in = 16'h1234;
        cyc();
        chk("rst_write.busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #1 chk_quiet("rst_write");
        cyc();
        reset = 1'b1;
        bus_idle();
        cyc();
        do_read(18'h00020, ref_mem[18'h00020], "r_rst");

        do_write(18'h00040, 16'h5555, 16'h6666, 6, "w_long");
        do_read(18'h00040, 16'h5555, "r_long");

        for (int it = 0; it < 10; it++) begin
            ra = ADDR_W'($urandom);
            rd = DATA_W'($urandom);
            rl = DATA_W'($urandom);
            rh = int'($urandom_range(1, 4));
            do_write(ra, rd, rl, rh, "w_rand");
            if (ref_mem.exists(ra)) do_read(ra, ref_mem[ra], "r_rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
